// File: rtl/spm_seq_ctrl.sv
// Sequencer for the serial-parallel multiplier carry-save array.
// Streams the multiplier LSB-first and deserialises the serial product.
module spm_seq_ctrl #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1,
    parameter int P_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mc,
    input  logic [WIDTH-1:0]   mp,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   spm_x,
    output logic               spm_y,
    output logic               spm_clr,
    input  logic               spm_p
);

    localparam int RUN_LEN = 2*WIDTH + P_LAT;
    localparam int CW = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] LAST  = CW'(RUN_LEN - 1);
    localparam logic [CW-1:0] LAT   = CW'(P_LAT);
    localparam logic [CW-1:0] Y_END = CW'(2*WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic             fill;
    logic [WIDTH-1:0] sr_next;

    // Upper half of the multiplier stream repeats the sign bit when signed.
    assign fill    = SIGNED ? sr[WIDTH-1] : 1'b0;
    assign sr_next = {fill, sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sr      <= '0;
            prod    <= '0;
            spm_x   <= '0;
            spm_y   <= 1'b0;
            spm_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        spm_x   <= mc;
                        sr      <= mp;
                        cnt     <= '0;
                        prod    <= '0;
                        spm_clr <= 1'b1;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                        state   <= S_CLEAR;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    spm_clr <= 1'b0;
                    spm_y   <= sr[0];
                    sr      <= sr_next;
                    cnt     <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (cnt >= LAT)
                        prod <= {spm_p, prod[2*WIDTH-1:1]};
                    if (cnt == LAST) begin
                        spm_y <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        spm_y <= (cnt < Y_END) ? sr[0] : 1'b0;
                        sr    <= sr_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
